// File: rtl/sp_ram_bist_ctrl_if.sv
// Single-port RAM access bus between the BIST initiator (master) and the RAM wrapper (slave).
// rdata is returned in the cycle after a read is issued.
interface sp_ram_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                    en;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output en, we, addr, wdata, be, input rdata);
  modport slave  (input en, we, addr, wdata, be, output rdata);
endinterface

// File: rtl/sp_ram_bist_ctrl.sv
// Memory BIST initiator: fills, checks or marches a single-port RAM with an
// address-in-data pattern and reports pass/fail, error count and first failing address.
module sp_ram_bist_ctrl #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  sp_ram_bist_ctrl_if.master    ram
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int N     = RAM_SIZE / BYTES;
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam int OFF   = $clog2(BYTES);
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;
  typedef enum logic [1:0] {M_FILL = 2'b00, M_CHECK = 2'b01, M_MARCH = 2'b10, M_RSVD = 2'b11} mode_e;

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   pattern_q, pattern_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    cmp_valid_q, cmp_valid_d;
  logic [K_W-1:0]          cmp_k_q, cmp_k_d;
  logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;
  logic                    en_q, en_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]        be_q, be_d;
  logic                    mismatch;
  logic [K_W-1:0]          k_nxt;

  // Address-in-data pattern: D(k) = pattern ^ k, so aliased words read back wrong.
  function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [DATA_WIDTH-1:0] pat,
                                                     input logic [K_W-1:0] k);
    return pat ^ DATA_WIDTH'(k);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [K_W-1:0] k);
    return ADDR_WIDTH'(k) << OFF;
  endfunction

  always_comb begin
    // NOTE: every *_d gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    mode_d      = mode_q;
    pattern_d   = pattern_q;
    k_d         = k_q;
    cmp_valid_d = 1'b0;
    cmp_k_d     = cmp_k_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    en_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = '0;
    k_nxt       = k_q + K_W'(1);

    // Compare the read issued last cycle against its recorded tag.
    mismatch = cmp_valid_q && (ram.rdata != exp_data(pattern_q, cmp_k_q));
    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0)    first_err_d = word_addr(cmp_k_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d      = mode_e'(mode_i);
          pattern_d   = pattern_i;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          k_d         = '0;
          addr_d      = '0;
          case (mode_e'(mode_i))
            M_FILL, M_MARCH: begin
              state_d = S_WRITE;
              busy_d  = 1'b1;
              en_d    = 1'b1;
              we_d    = 1'b1;
              be_d    = '1;
              wdata_d = exp_data(pattern_i, '0);
            end
            M_CHECK: begin
              state_d = S_READ;
              busy_d  = 1'b1;
              en_d    = 1'b1;
              be_d    = '1;
            end
            default: begin
              state_d = S_DONE;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end
          endcase
        end
      end
      S_WRITE: begin
        if (k_q == K_LAST) begin
          if (mode_q == M_MARCH) begin
            // March rolls straight into the read phase with no idle cycle.
            state_d = S_READ;
            k_d     = '0;
            en_d    = 1'b1;
            be_d    = '1;
            addr_d  = '0;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == 16'd0);
          end
        end else begin
          k_d     = k_nxt;
          en_d    = 1'b1;
          we_d    = 1'b1;
          be_d    = '1;
          addr_d  = word_addr(k_nxt);
          wdata_d = exp_data(pattern_q, k_nxt);
        end
      end
      S_READ: begin
        cmp_valid_d = 1'b1;
        cmp_k_d     = k_q;
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d    = k_nxt;
          en_d   = 1'b1;
          be_d   = '1;
          addr_d = word_addr(k_nxt);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_cnt_d == 16'd0);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mode_q      <= M_FILL;
      pattern_q   <= '0;
      k_q         <= '0;
      cmp_valid_q <= 1'b0;
      cmp_k_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      k_q         <= k_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_k_q     <= cmp_k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign ram.en           = en_q;
  assign ram.we           = we_q;
  assign ram.addr         = addr_q;
  assign ram.wdata        = wdata_q;
  assign ram.be           = be_q;

endmodule

// File: tb/tb_sp_ram_bist_ctrl.sv
// Bench for sp_ram_bist_ctrl: a 64-byte RAM model with per-word read-fault masks and an
// expected-access scoreboard, plus a 256 KiB instance with an always-wrong RAM for saturation.
module tb_sp_ram_bist_ctrl;
  localparam int RAM_SIZE = 64;
  localparam int AW       = 6;
  localparam int DW       = 32;
  localparam int N        = 16;
  localparam int SAT_SIZE = 262144;
  localparam int SAT_AW   = 18;
  localparam int SAT_N    = 65536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, start_i;
  logic [1:0]    mode_i;
  logic [DW-1:0] pattern_i;
  logic          busy_o, done_o, pass_o;
  logic [15:0]   err_cnt_o;
  logic [AW-1:0] first_err_addr_o;

  sp_ram_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sp_ram_bist_ctrl #(.RAM_SIZE(RAM_SIZE), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .pattern_i(pattern_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .ram(bus)
  );

  logic              sat_rst, sat_start;
  logic [1:0]        sat_mode;
  logic [DW-1:0]     sat_pat;
  logic              sat_busy, sat_done, sat_pass;
  logic [15:0]       sat_err;
  logic [SAT_AW-1:0] sat_first;

  sp_ram_bist_ctrl_if #(.ADDR_WIDTH(SAT_AW), .DATA_WIDTH(DW)) sat_bus ();
  assign sat_bus.rdata = 32'hFFFF_0000;

  sp_ram_bist_ctrl #(.RAM_SIZE(SAT_SIZE), .DATA_WIDTH(DW)) sat_dut (
    .clk(clk), .rst_i(sat_rst), .start_i(sat_start), .mode_i(sat_mode), .pattern_i(sat_pat),
    .busy_o(sat_busy), .done_o(sat_done), .pass_o(sat_pass), .err_cnt_o(sat_err),
    .first_err_addr_o(sat_first), .ram(sat_bus)
  );

  // RAM model: byte-enabled writes, registered reads XORed with a per-word fault mask.
  logic [DW-1:0] mem  [N];
  logic [DW-1:0] flip [N];
  always @(posedge clk) begin
    if (bus.en) begin
      if (bus.we) begin
        for (int b = 0; b < DW / 8; b++)
          if (bus.be[b]) mem[bus.addr[AW-1:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
      end else begin
        bus.rdata <= mem[bus.addr[AW-1:2]] ^ flip[bus.addr[AW-1:2]];
      end
    end
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  acc_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push_writes(input logic [DW-1:0] pat);
    acc_t a;
    for (int k = 0; k < N; k++) begin
      a.we = 1'b1; a.addr = AW'(k * 4); a.wdata = pat ^ DW'(k);
      exp_q.push_back(a);
    end
  endtask

  task automatic push_reads();
    acc_t a;
    for (int k = 0; k < N; k++) begin
      a.we = 1'b0; a.addr = AW'(k * 4); a.wdata = '0;
      exp_q.push_back(a);
    end
  endtask

  // Expected error status from the bench's own RAM contents and fault masks.
  task automatic model_expect(input logic [1:0] mode, input logic [DW-1:0] pat,
                              output logic [15:0] e, output logic [AW-1:0] f);
    logic [DW-1:0] stored;
    e = '0; f = '0;
    if (mode == 2'b01 || mode == 2'b10) begin
      for (int k = 0; k < N; k++) begin
        stored = (mode == 2'b10) ? (pat ^ DW'(k)) : mem[k];
        if ((stored ^ flip[k]) !== (pat ^ DW'(k))) begin
          if (e == 16'd0) f = AW'(k * 4);
          e = e + 16'd1;
        end
      end
    end
  endtask

  // Starts a run, matches every bus access against the scoreboard and checks done timing and status.
  task automatic run_watch(input string name, input logic [1:0] mode, input logic [DW-1:0] pat,
                           input int exp_done, input int pulse_at);
    logic [15:0]   e_err;
    logic [AW-1:0] e_first;
    logic          e_pass;
    acc_t          a;
    int            done_cyc;
    int            extra;
    model_expect(mode, pat, e_err, e_first);
    e_pass = (e_err == 16'd0);
    if (mode == 2'b00 || mode == 2'b10) push_writes(pat);
    if (mode == 2'b01 || mode == 2'b10) push_reads();

    @(negedge clk);
    start_i = 1'b1; mode_i = mode; pattern_i = pat;
    @(posedge clk); #1;
    start_i = 1'b0; mode_i = 2'b11; pattern_i = ~pat;
    done_cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.en === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected access cycle %0d: we=%b addr=%h", name, c, bus.we, bus.addr);
        end else begin
          a = exp_q.pop_front();
          if (bus.we !== a.we || bus.addr !== a.addr || bus.be !== 4'hF || busy_o !== 1'b1 ||
              (a.we && bus.wdata !== a.wdata)) begin
            n_err++;
            $display("FAIL %s access cycle %0d: got we=%b addr=%h wdata=%h be=%h busy=%b, want we=%b addr=%h wdata=%h be=f busy=1",
                     name, c, bus.we, bus.addr, bus.wdata, bus.be, busy_o, a.we, a.addr, a.wdata);
          end
        end
      end
      if (done_o === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (c == pulse_at) begin
        start_i = 1'b1; mode_i = 2'b11; pattern_i = 32'hDEAD_BEEF;
      end else if (c == pulse_at + 1) begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;

    n_vec++;
    if (done_cyc != exp_done) begin
      n_err++;
      $display("FAIL %s done cycle: got %0d want %0d (0 = none)", name, done_cyc, exp_done);
    end
    n_vec++;
    if (err_cnt_o !== e_err) begin
      n_err++;
      $display("FAIL %s err_cnt: got %h want %h", name, err_cnt_o, e_err);
    end
    n_vec++;
    if (first_err_addr_o !== e_first) begin
      n_err++;
      $display("FAIL %s first_err_addr: got %h want %h", name, first_err_addr_o, e_first);
    end
    n_vec++;
    if (pass_o !== e_pass || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s pass/busy at done: got %b/%b want %b/0", name, pass_o, busy_o, e_pass);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s missing accesses: got %0d left want 0", name, exp_q.size());
      exp_q.delete();
    end

    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_o !== 1'b0 || bus.en !== 1'b0) extra++;
    end
    n_vec++;
    if (extra != 0 || pass_o !== e_pass || err_cnt_o !== e_err) begin
      n_err++;
      $display("FAIL %s after done: got %0d extra done/access, pass=%b err=%h, want 0, %b, %h",
               name, extra, pass_o, err_cnt_o, e_pass, e_err);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; mode_i = 2'b00; pattern_i = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset status: got busy=%b done=%b pass=%b want 0 0 0", busy_o, done_o, pass_o);
    end
    n_vec++;
    if (err_cnt_o !== 16'd0 || first_err_addr_o !== '0) begin
      n_err++;
      $display("FAIL reset errors: got err=%h first=%h want 0 0", err_cnt_o, first_err_addr_o);
    end
    n_vec++;
    if (bus.en !== 1'b0 || bus.we !== 1'b0 || bus.addr !== '0 || bus.wdata !== '0 || bus.be !== '0) begin
      n_err++;
      $display("FAIL reset bus: got en=%b we=%b addr=%h wdata=%h be=%h want all 0",
               bus.en, bus.we, bus.addr, bus.wdata, bus.be);
    end
    rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.en !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset over start: got en=%b busy=%b want 0 0", bus.en, busy_o);
    end
  endtask

  task automatic test_fill();
    run_watch("fill", 2'b00, 32'hA5A5_0000, N + 1, 0);
  endtask

  task automatic test_check();
    run_watch("check", 2'b01, 32'hA5A5_0000, N + 2, 0);
  endtask

  task automatic test_march_flip();
    flip[5] = 32'h0000_0008;
    run_watch("march_flip", 2'b10, 32'h0F0F_3C3C, 2 * N + 2, 0);
    flip[5] = '0;
  endtask

  task automatic test_march_two_faults_start_ignored();
    flip[9] = 32'h8000_0000;
    flip[2] = 32'h0000_0001;
    run_watch("march_two", 2'b10, 32'h5555_AAAA, 2 * N + 2, 10);
    flip[9] = '0;
    flip[2] = '0;
  endtask

  task automatic test_reset_midrun();
    acc_t a;
    int   extra;
    for (int k = 0; k < 8; k++) begin
      a.we = 1'b1; a.addr = AW'(k * 4); a.wdata = 32'hC0DE_0000 ^ DW'(k);
      exp_q.push_back(a);
    end
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'b00; pattern_i = 32'hC0DE_0000;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_vec++;
      if (exp_q.size() == 0 || bus.en !== 1'b1) begin
        n_err++;
        $display("FAIL rst_mid access cycle %0d: got en=%b want 1", c, bus.en);
      end else begin
        a = exp_q.pop_front();
        if (bus.we !== 1'b1 || bus.addr !== a.addr || bus.wdata !== a.wdata) begin
          n_err++;
          $display("FAIL rst_mid access cycle %0d: got addr=%h wdata=%h want %h %h",
                   c, bus.addr, bus.wdata, a.addr, a.wdata);
        end
      end
    end
    rst_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.en !== 1'b0 || busy_o !== 1'b0 || err_cnt_o !== 16'd0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid after reset: got en=%b busy=%b err=%h done=%b want 0 0 0 0",
               bus.en, busy_o, err_cnt_o, done_o);
    end
    rst_i = 1'b0;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_o !== 1'b0 || bus.en !== 1'b0) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL rst_mid idle after reset: got %0d done/access cycles want 0", extra);
    end
    run_watch("fill_after_rst", 2'b00, 32'h7777_0000, N + 1, 0);
  endtask

  task automatic test_reserved();
    run_watch("reserved", 2'b11, 32'h1111_2222, 1, 0);
  endtask

  task automatic test_back_to_back();
    acc_t a;
    int   n_done, d1, d2;
    push_writes(32'h3C00_0000);
    push_writes(32'h3C00_0000);
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'b00; pattern_i = 32'h3C00_0000;
    @(posedge clk); #1;
    n_done = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.en === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b unexpected access cycle %0d addr=%h", c, bus.addr);
        end else begin
          a = exp_q.pop_front();
          if (bus.we !== 1'b1 || bus.addr !== a.addr || bus.wdata !== a.wdata) begin
            n_err++;
            $display("FAIL b2b access cycle %0d: got we=%b addr=%h wdata=%h want 1 %h %h",
                     c, bus.we, bus.addr, bus.wdata, a.addr, a.wdata);
          end
        end
      end
      if (done_o === 1'b1) begin
        n_done++;
        if (n_done == 1) d1 = c;
        else if (n_done == 2) d2 = c;
      end
      if (c == 19) start_i = 1'b0;
    end
    n_vec++;
    if (n_done != 2 || d1 != N + 1 || d2 != 2 * N + 3) begin
      n_err++;
      $display("FAIL b2b done pulses: got %0d at %0d,%0d want 2 at %0d,%0d",
               n_done, d1, d2, N + 1, 2 * N + 3);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b missing accesses: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_saturation();
    int done_cyc, reads;
    @(negedge clk);
    sat_rst = 1'b0; sat_start = 1'b1; sat_mode = 2'b01; sat_pat = '0;
    @(posedge clk); #1;
    sat_start = 1'b0;
    done_cyc = 0; reads = 0;
    for (int c = 1; c <= 70000; c++) begin
      @(negedge clk);
      if (sat_bus.en === 1'b1) reads++;
      if (sat_done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    n_vec++;
    if (done_cyc != SAT_N + 2 || reads != SAT_N) begin
      n_err++;
      $display("FAIL sat timing: got done=%0d reads=%0d want %0d %0d", done_cyc, reads, SAT_N + 2, SAT_N);
    end
    n_vec++;
    if (sat_err !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat err_cnt: got %h want ffff", sat_err);
    end
    n_vec++;
    if (sat_first !== '0 || sat_pass !== 1'b0) begin
      n_err++;
      $display("FAIL sat first/pass: got %h/%b want 0/0", sat_first, sat_pass);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; mode_i = 2'b00; pattern_i = '0;
    sat_rst = 1'b1; sat_start = 1'b0; sat_mode = 2'b00; sat_pat = '0;
    for (int k = 0; k < N; k++) flip[k] = '0;
    test_reset();
    test_fill();
    test_check();
    test_march_flip();
    test_march_two_faults_start_ignored();
    test_reset_midrun();
    test_reserved();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
